// File: rtl/psum_accum_buf.sv
// psum_accum_buf
// Output-stage partial-sum buffer between the corelet output FIFO and the
// SFP/pmem path. Holds 2**addr_bw vectors of col signed lanes. Each incoming
// beat either overwrites an entry or is added into it through a two-stage
// read-modify-write pipeline with same-address forwarding. A block clear
// sequence zeroes every entry, and a read port returns an entry with optional
// per-lane ReLU.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      synchronous active-high reset
//   in_valid   psum beat offered
//   in_ready   beat accepted when in_valid && in_ready at the edge
//   in_data    psum vector, lane i at [i*psum_bw +: psum_bw]
//   in_addr    target entry
//   in_acc     1 = entry += in_data, 0 = entry = in_data
//   clear      request zeroing of all entries
//   rd_req     read request (honoured only in IDLE)
//   rd_addr    entry to read
//   relu_en    per-lane max(0,x) on the read data, sampled with rd_req
//   out_valid  out_data valid this cycle
//   out_data   read result, holds its value when out_valid is low
//   busy       draining, clearing or pipeline not empty
module psum_accum_buf #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 4,
  parameter int sat_en  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [col*psum_bw-1:0]   in_data,
  input  logic [addr_bw-1:0]       in_addr,
  input  logic                     in_acc,
  input  logic                     clear,
  input  logic                     rd_req,
  input  logic [addr_bw-1:0]       rd_addr,
  input  logic                     relu_en,
  output logic                     out_valid,
  output logic [col*psum_bw-1:0]   out_data,
  output logic                     busy
);

  localparam int depth  = 1 << addr_bw;
  localparam int vec_bw = col * psum_bw;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [addr_bw-1:0]   clr_cnt_q, clr_cnt_d;

  // Entry storage. Kept in flops because reset must zero every entry in a
  // single cycle.
  logic [vec_bw-1:0]    mem_q [depth];

  // Stage 1: accepted beat plus registered read of its target entry.
  logic                 s1_valid_q;
  logic [addr_bw-1:0]   s1_addr_q;
  logic [vec_bw-1:0]    s1_data_q;
  logic                 s1_acc_q;
  logic [vec_bw-1:0]    s1_rd_q;

  // Stage 2: copy of the last written entry, used for forwarding.
  logic                 s2_valid_q;
  logic [addr_bw-1:0]   s2_addr_q;
  logic [vec_bw-1:0]    s2_result_q;

  // Read port pipeline.
  logic                 rd_valid_q;
  logic                 rd_relu_q;
  logic [vec_bw-1:0]    rd_data_q;
  logic                 out_valid_q;
  logic [vec_bw-1:0]    out_data_q;

  logic                 accept;
  logic                 rd_fire;
  logic                 fwd_sel;
  logic [vec_bw-1:0]    operand;
  logic [vec_bw-1:0]    result_d;
  logic [vec_bw-1:0]    relu_data;

  assign in_ready = (state_q == ST_IDLE) && !clear && !reset;
  assign accept   = in_valid && in_ready;
  assign rd_fire  = rd_req && (state_q == ST_IDLE);

  assign busy      = !reset && ((state_q != ST_IDLE) || s1_valid_q || s2_valid_q);
  assign out_valid = out_valid_q && !reset;
  assign out_data  = out_data_q;

  // The registered read in S1 happened while the previous beat was still
  // being written, so when that beat targeted the same entry its result must
  // replace the stale read.
  assign fwd_sel = s2_valid_q && (s2_addr_q == s1_addr_q);
  assign operand = fwd_sel ? s2_result_q : s1_rd_q;

  // ---------------------------------------------------------------------
  // Per-lane arithmetic and ReLU
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < col; gi++) begin : g_lane
      logic [psum_bw-1:0] op_a;
      logic [psum_bw-1:0] op_b;
      logic [psum_bw:0]   sum_ext;
      logic               ovf;
      logic [psum_bw-1:0] add_res;
      logic [psum_bw-1:0] rd_lane;

      assign op_a    = operand[gi*psum_bw +: psum_bw];
      assign op_b    = s1_data_q[gi*psum_bw +: psum_bw];
      // Sign-extend by one bit; overflow when the two top bits disagree.
      assign sum_ext = {op_a[psum_bw-1], op_a} + {op_b[psum_bw-1], op_b};
      assign ovf     = sum_ext[psum_bw] ^ sum_ext[psum_bw-1];

      if (sat_en != 0) begin : g_sat
        // The true sign of the sum is the extended top bit.
        assign add_res = !ovf ? sum_ext[psum_bw-1:0] :
                         sum_ext[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} :
                                            {1'b0, {(psum_bw-1){1'b1}}};
      end else begin : g_wrap
        assign add_res = sum_ext[psum_bw-1:0];
      end

      assign result_d[gi*psum_bw +: psum_bw] = s1_acc_q ? add_res : op_b;

      assign rd_lane = rd_data_q[gi*psum_bw +: psum_bw];
      assign relu_data[gi*psum_bw +: psum_bw] =
        (rd_relu_q && rd_lane[psum_bw-1]) ? '0 : rd_lane;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // FSM: IDLE -> DRAIN (wait for pipeline empty) -> CLEAR (depth cycles)
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (clear) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {addr_bw{1'b1}}) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Entry storage: S2 write or clear-sequence zeroing (never both, since
  // CLEAR is only entered once the pipeline has drained).
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < depth; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      if (s1_valid_q) begin
        mem_q[s1_addr_q] <= result_d;
      end
      if (state_q == ST_CLEAR) begin
        mem_q[clr_cnt_q] <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Write pipeline registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_data_q   <= '0;
      s1_acc_q    <= 1'b0;
      s1_rd_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_addr_q   <= '0;
      s2_result_q <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q <= in_addr;
        s1_data_q <= in_data;
        s1_acc_q  <= in_acc;
        s1_rd_q   <= mem_q[in_addr];
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_addr_q   <= s1_addr_q;
        s2_result_q <= result_d;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read port: registered read, then ReLU into the output register.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q  <= 1'b0;
      rd_relu_q   <= 1'b0;
      rd_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_relu_q <= relu_en;
        rd_data_q <= mem_q[rd_addr];
      end
      out_valid_q <= rd_valid_q;
      if (rd_valid_q) begin
        out_data_q <= relu_data;
      end
    end
  end

endmodule

// File: tb/tb_psum_accum_buf.sv
module tb_psum_accum_buf;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int AW  = 4;
  localparam int VW  = COL * BW;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [VW-1:0] in_data;
  logic [AW-1:0] in_addr;
  logic          in_acc;
  logic          clear;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          relu_en;

  logic          in_ready_s, out_valid_s, busy_s;
  logic [VW-1:0] out_data_s;
  logic          in_ready_w, out_valid_w, busy_w;
  logic [VW-1:0] out_data_w;

  int checks   = 0;
  int failures = 0;

  psum_accum_buf #(.col(COL), .psum_bw(BW), .addr_bw(AW), .sat_en(1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_addr(in_addr), .in_acc(in_acc), .clear(clear),
    .rd_req(rd_req), .rd_addr(rd_addr), .relu_en(relu_en),
    .out_valid(out_valid_s), .out_data(out_data_s), .busy(busy_s)
  );

  psum_accum_buf #(.col(COL), .psum_bw(BW), .addr_bw(AW), .sat_en(0)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_data(in_data), .in_addr(in_addr), .in_acc(in_acc), .clear(clear),
    .rd_req(rd_req), .rd_addr(rd_addr), .relu_en(relu_en),
    .out_valid(out_valid_w), .out_data(out_data_w), .busy(busy_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] vec_all(input logic [BW-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] vec_ramp(input int m);
    logic [VW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(m * (i + 1));
    return r;
  endfunction

  function automatic logic [VW-1:0] vec_two(input logic [BW-1:0] l0, input logic [BW-1:0] l1);
    logic [VW-1:0] r;
    r = '0;
    r[0 +: BW]  = l0;
    r[BW +: BW] = l1;
    return r;
  endfunction

  // Offer one beat for one edge; the caller knows it should be accepted.
  task automatic write_beat(input logic [AW-1:0] a, input logic [VW-1:0] d, input logic acc);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_acc   = acc;
    check("wr_in_ready", VW'(in_ready_s), VW'(1));
    step();
    in_valid = 1'b0;
  endtask

  // rd_req for one edge; out_valid expected for exactly the cycle after the next edge.
  task automatic read_entry(input string tag, input logic [AW-1:0] a, input logic relu,
                            input logic [VW-1:0] exp_s, input logic [VW-1:0] exp_w);
    rd_req  = 1'b1;
    rd_addr = a;
    relu_en = relu;
    step();
    rd_req  = 1'b0;
    relu_en = 1'b0;
    step();
    check({tag, "_ovalid"}, VW'({out_valid_s, out_valid_w}), VW'(2'b11));
    check({tag, "_sat"}, out_data_s, exp_s);
    check({tag, "_wrap"}, out_data_w, exp_w);
    $display("read %s addr=%0d relu=%0d sat=%h wrap=%h", tag, a, relu, out_data_s, out_data_w);
    step();
    check({tag, "_ovalid_drop"}, VW'({out_valid_s, out_valid_w}), VW'(2'b00));
  endtask

  // Count cycles with busy high, starting at the current cycle; optionally
  // keep rd_req asserted throughout to confirm reads are dropped.
  task automatic wait_busy(input string tag, input int exp_cycles);
    int  n;
    logic ov;
    logic rdy;
    n   = 0;
    ov  = 1'b0;
    rdy = 1'b0;
    rd_req  = 1'b1;
    rd_addr = 4'd3;
    while (busy_s && n < 100) begin
      ov  = ov | out_valid_s | out_valid_w;
      rdy = rdy | in_ready_s;
      step();
      n++;
    end
    rd_req = 1'b0;
    ov = ov | out_valid_s | out_valid_w;
    step();
    ov = ov | out_valid_s | out_valid_w;
    check({tag, "_busy_cycles"}, VW'(n), VW'(exp_cycles));
    check({tag, "_no_ovalid"}, VW'(ov), VW'(0));
    check({tag, "_no_ready"}, VW'(rdy), VW'(0));
    $display("clear %s busy_cycles=%0d", tag, n);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_addr  = '0;
    in_acc   = 1'b0;
    clear    = 1'b0;
    rd_req   = 1'b0;
    rd_addr  = '0;
    relu_en  = 1'b0;

    // Reset
    step();
    step();
    check("rst_busy", VW'({busy_s, busy_w}), VW'(0));
    check("rst_ready", VW'({in_ready_s, in_ready_w}), VW'(0));
    reset = 1'b0;
    #1;
    check("post_rst_ready", VW'({in_ready_s, in_ready_w}), VW'(2'b11));
    check("post_rst_ovalid", VW'({out_valid_s, out_valid_w}), VW'(0));
    check("post_rst_odata", out_data_s, '0);
    $display("reset done");

    // Overwrite then read back
    write_beat(4'd3, vec_all(16'd5), 1'b0);
    check("wr_busy", VW'(busy_s), VW'(1));
    step();
    read_entry("ovw3", 4'd3, 1'b0, vec_all(16'd5), vec_all(16'd5));
    read_entry("ovw4", 4'd4, 1'b0, '0, '0);

    // Back-to-back accumulate into one entry
    for (int b = 0; b < 4; b++) write_beat(4'd7, vec_ramp(1), 1'b1);
    step();
    read_entry("acc7", 4'd7, 1'b0, vec_ramp(4), vec_ramp(4));
    check("acc7_lane7", VW'(out_data_s[7*BW +: BW]), VW'(32));

    // Saturation / wrap and ReLU
    write_beat(4'd9, vec_two(16'sd32000, -16'sd32000), 1'b0);
    write_beat(4'd9, vec_two(16'sd1000, -16'sd1000), 1'b1);
    step();
    read_entry("sat9", 4'd9, 1'b0, vec_two(16'h7FFF, 16'h8000), vec_two(16'h80E8, 16'h7F18));
    read_entry("sat9_relu", 4'd9, 1'b1, vec_two(16'h7FFF, 16'h0000), vec_two(16'h0000, 16'h7F18));

    // Clear with beats in flight
    write_beat(4'd0, vec_all(16'd1), 1'b0);
    write_beat(4'd1, vec_all(16'd2), 1'b0);
    clear = 1'b1;
    #1;
    check("clr_ready_now", VW'({in_ready_s, in_ready_w}), VW'(0));
    step();
    clear = 1'b0;
    wait_busy("inflight", 18);
    read_entry("clr0", 4'd0, 1'b0, '0, '0);
    read_entry("clr1", 4'd1, 1'b0, '0, '0);
    read_entry("clr7", 4'd7, 1'b0, '0, '0);
    read_entry("clr9", 4'd9, 1'b0, '0, '0);

    // Simultaneous clear and in_valid
    write_beat(4'd2, vec_all(16'h0022), 1'b0);
    step();
    read_entry("pre2", 4'd2, 1'b0, vec_all(16'h0022), vec_all(16'h0022));
    clear    = 1'b1;
    in_valid = 1'b1;
    in_addr  = 4'd6;
    in_data  = vec_all(16'h0033);
    in_acc   = 1'b0;
    #1;
    check("simul_ready", VW'({in_ready_s, in_ready_w}), VW'(0));
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    wait_busy("simul", 17);
    read_entry("simul2", 4'd2, 1'b0, '0, '0);
    read_entry("simul6", 4'd6, 1'b0, '0, '0);

    // Reset mid-pipeline
    write_beat(4'd5, vec_all(16'd9), 1'b0);
    step();
    read_entry("pre5", 4'd5, 1'b0, vec_all(16'd9), vec_all(16'd9));
    rd_req  = 1'b1;
    rd_addr = 4'd5;
    write_beat(4'd5, vec_all(16'd1), 1'b1);
    rd_req = 1'b0;
    reset  = 1'b1;
    #1;
    check("mid_rst_busy", VW'({busy_s, busy_w}), VW'(0));
    check("mid_rst_ovalid", VW'({out_valid_s, out_valid_w}), VW'(0));
    step();
    check("mid_rst_busy2", VW'({busy_s, busy_w}), VW'(0));
    check("mid_rst_ovalid2", VW'({out_valid_s, out_valid_w}), VW'(0));
    check("mid_rst_odata", out_data_s, '0);
    reset = 1'b0;
    step();
    check("after_rst_busy", VW'({busy_s, busy_w}), VW'(0));
    check("after_rst_ovalid", VW'({out_valid_s, out_valid_w}), VW'(0));
    read_entry("rst5", 4'd5, 1'b0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/psum_accum_buf.md
Name: psum_accum_buf

Overview:
- Parametrised output-stage buffer placed between the corelet output FIFO and the SFP/pmem path.
- Holds `depth` partial-sum vectors of `col` lanes each.
- Every incoming psum vector either overwrites an entry or is added into it, through a 2-stage read-modify-write pipeline with same-address forwarding.
- Provides a block clear sequence and a read port with optional per-lane ReLU and signed saturation.

Parameters:
- col, 8, number of psum lanes per vector
- psum_bw, 16, signed two's-complement lane width
- addr_bw, 4, entry address width; depth = 2**addr_bw entries
- sat_en, 1, 1 = saturating lane add, 0 = wrap-around add

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  psum beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready at edge
- in_data  in  col*psum_bw  psum vector, lane i at [i*psum_bw +: psum_bw]
- in_addr  in  addr_bw  target entry
- in_acc  in  1  1 = entry += in_data, 0 = entry = in_data
- clear  in  1  request zeroing of all entries
- rd_req  in  1  read request
- rd_addr  in  addr_bw  entry to read
- relu_en  in  1  apply per-lane max(0,x) on read data, sampled with rd_req
- out_valid  out  1  out_data valid this cycle
- out_data  out  col*psum_bw  read result
- busy  out  1  high in DRAIN or CLEAR, or while any pipeline stage valid

Behaviour:
- Reset: synchronous, active-high; dominates every other input and may be asserted mid-operation.
  - All entries are set to 0 and both pipeline stages are invalidated; any in-flight write is discarded.
  - FSM goes to IDLE.
  - out_valid=0, out_data=0, busy=0.
- in_ready = (state==IDLE) && !clear && !reset. It is combinational from state and clear.
- FSM:
  - IDLE: clear=1 goes to DRAIN; clear has priority over in_valid in the same cycle, so no beat is accepted.
  - DRAIN: waits until both pipeline stages are empty, then goes to CLEAR.
  - CLEAR: a counter zeroes entry k at cycle k, k=0..depth-1. After the last entry the FSM returns to IDLE, so CLEAR lasts exactly depth cycles.
  - clear asserted in DRAIN or CLEAR is ignored.
- Write pipeline:
  - S1, at the accept edge t: latches addr, data and acc, and performs a registered read of entry[addr].
  - S2, at edge t+1: computes the result and writes the entry.
    - result = acc ? lane-wise (S1 read value + data) : data.
    - The entry is visible to a read sampled at edge t+2 or later.
- Forwarding: if the S2 write address equals the S1 address in the same cycle, S2 uses the S2 result as its operand instead of the stale registered read. N back-to-back accumulates to one address must equal the sequential sum.
- Throughput: 1 beat per cycle in IDLE; there is no backpressure in IDLE.
- Arithmetic, per lane, signed psum_bw:
  - sat_en=1: overflow clamps to +(2^(psum_bw-1)-1) and underflow clamps to -2^(psum_bw-1).
  - sat_en=0: result wraps modulo 2^psum_bw.
  - There is no cross-lane carry.
- Read port:
  - Reads are honoured only in IDLE with no active reset; in DRAIN or CLEAR rd_req is dropped and out_valid stays 0.
  - rd_req sampled at edge t gives out_valid=1 for one cycle after edge t+1, with out_data = entry[rd_addr] as stored at edge t. In-flight S1/S2 writes are not visible.
  - With relu_en=1, negative lanes read as 0.
  - out_data holds its last value when out_valid=0.
- Reads and writes are independent: a read and a write to the same address at the same edge returns the pre-write value.
- busy deasserts the first cycle the FSM is in IDLE with both stages empty.

Test Plan:
- Reset, then overwrite writes:
  - Stimulus: write addr 3 = all lanes 5 with in_acc=0; then read addr 3 at accept+2.
  - Required: out_valid one cycle later; out_data all lanes 5. Reading addr 4 returns 0.
- Back-to-back accumulate (forwarding):
  - Stimulus: 4 consecutive beats to addr 7, in_acc=1, lane i = i+1.
  - Required: read shows lane i = 4*(i+1). Lane 7 = 32.
- Saturation and ReLU:
  - Stimulus: sat_en=1, psum_bw=16. Write 32000 then accumulate 1000 on lane 0. Write -32000 then accumulate -1000 on lane 1.
  - Required: lane0 = 32767, lane1 = -32768.
  - Same read with relu_en=1: lane1 = 0.
  - With sat_en=0 the same stimulus gives lane0 = -32536.
- Clear with beats in flight:
  - Stimulus: accept beats at addrs 0 and 1, and assert clear the next cycle.
  - Required: in_ready=0 immediately; DRAIN lasts until S2 is empty; then CLEAR lasts 16 cycles with busy=1.
  - Required: rd_req during CLEAR gives no out_valid.
  - Required: afterwards all entries read 0.
- Simultaneous clear and in_valid in IDLE:
  - Required: the beat is not accepted (in_ready=0).
  - Required: all entries are 0 after CLEAR, and the previously held value at addr 2 is gone.
- Reset mid-pipeline:
  - Stimulus: accept an accumulate to addr 5 (entry previously 9), then assert reset on the next edge.
  - Required: entry 5 reads 0; out_valid=0 and busy=0 during and after reset.
